// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and constants for the memory port arbiter
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_e;

    localparam logic OWNER_CPU = 1'b0;
    localparam logic OWNER_LDR = 1'b1;

    // A zero-wait configuration still needs a one-bit counter.
    function automatic int cnt_width(input int wait_cycles);
        int w;
        w = $clog2(wait_cycles + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - requester and memory buses of the memory port arbiter
interface mem_port_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          cpu_req;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic [DW-1:0] cpu_rdata;
    logic          cpu_ack;

    logic          ldr_req;
    logic          ldr_we;
    logic [AW-1:0] ldr_addr;
    logic [DW-1:0] ldr_wdata;
    logic [DW-1:0] ldr_rdata;
    logic          ldr_ack;

    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_rdata, cpu_ack,
        input  ldr_req, ldr_we, ldr_addr, ldr_wdata,
        output ldr_rdata, ldr_ack,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_rdata, cpu_ack,
        output ldr_req, ldr_we, ldr_addr, ldr_wdata,
        input  ldr_rdata, ldr_ack,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata
    );

endinterface

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-input round-robin selector with last-grant memory
module rr_arb2
    import mem_arb_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       update_en,
    output logic       grant_valid,
    output logic       grant
);

    logic last_grant_q;
    logic last_grant_d;

    always_comb begin
        grant_valid = |req;
        grant       = OWNER_CPU;
        if (req == 2'b11) begin
            grant = ~last_grant_q;
        end else if (req[1]) begin
            grant = OWNER_LDR;
        end
        last_grant_d = last_grant_q;
        if (update_en && grant_valid) begin
            last_grant_d = grant;
        end
    end

    // Starting from the loader lets the CPU win the first tie.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_grant_q <= OWNER_LDR;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one memory between the CPU and the loader with fixed wait states
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW          = 32,
    parameter int DW          = 32,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                clk,
    input  logic                reset,
    mem_port_arbiter_if.slave   bus,
    output logic                busy,
    output logic                owner
);

    localparam int            CW       = cnt_width(WAIT_CYCLES);
    localparam logic [CW-1:0] CNT_INIT = CW'(WAIT_CYCLES);

    state_e        state_q,     state_d;
    logic [CW-1:0] cnt_q,       cnt_d;
    logic          we_q,        we_d;
    logic [AW-1:0] addr_q,      addr_d;
    logic [DW-1:0] wdata_q,     wdata_d;
    logic          owner_q,     owner_d;
    logic [DW-1:0] cpu_rdata_q, cpu_rdata_d;
    logic [DW-1:0] ldr_rdata_q, ldr_rdata_d;
    logic          cpu_ack_q,   cpu_ack_d;
    logic          ldr_ack_q,   ldr_ack_d;

    logic          grant_valid;
    logic          grant;

    rr_arb2 u_rr_arb2 (
        .clk         (clk),
        .reset       (reset),
        .req         ({bus.ldr_req, bus.cpu_req}),
        .update_en   (state_q == IDLE),
        .grant_valid (grant_valid),
        .grant       (grant)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        owner_d     = owner_q;
        cpu_rdata_d = cpu_rdata_q;
        ldr_rdata_d = ldr_rdata_q;
        cpu_ack_d   = 1'b0;
        ldr_ack_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (grant_valid) begin
                    owner_d = grant;
                    cnt_d   = CNT_INIT;
                    state_d = ACCESS;
                    if (grant == OWNER_LDR) begin
                        we_d    = bus.ldr_we;
                        addr_d  = bus.ldr_addr;
                        wdata_d = bus.ldr_wdata;
                    end else begin
                        we_d    = bus.cpu_we;
                        addr_d  = bus.cpu_addr;
                        wdata_d = bus.cpu_wdata;
                    end
                end
            end
            ACCESS: begin
                if (cnt_q == '0) begin
                    state_d = RESP;
                    if (owner_q == OWNER_LDR) begin
                        ldr_ack_d = 1'b1;
                        if (!we_q) begin
                            ldr_rdata_d = bus.mem_rdata;
                        end
                    end else begin
                        cpu_ack_d = 1'b1;
                        if (!we_q) begin
                            cpu_rdata_d = bus.mem_rdata;
                        end
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            owner_q     <= OWNER_CPU;
            cpu_rdata_q <= '0;
            ldr_rdata_q <= '0;
            cpu_ack_q   <= 1'b0;
            ldr_ack_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            owner_q     <= owner_d;
            cpu_rdata_q <= cpu_rdata_d;
            ldr_rdata_q <= ldr_rdata_d;
            cpu_ack_q   <= cpu_ack_d;
            ldr_ack_q   <= ldr_ack_d;
        end
    end

    // Enables decode straight from the state flop so a reset drops them without a clock edge.
    assign bus.mem_en    = (state_q == ACCESS);
    assign bus.mem_we    = (state_q == ACCESS) && we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.cpu_rdata = cpu_rdata_q;
    assign bus.ldr_rdata = ldr_rdata_q;
    assign bus.cpu_ack   = cpu_ack_q;
    assign bus.ldr_ack   = ldr_ack_q;
    assign busy          = (state_q != IDLE);
    assign owner         = owner_q;

endmodule
